mc_sequencer: RTL and testbench

MC_SEQUENCER -- requirements
Module: mc_sequencer

---
 rtl/mc_sequencer_pkg.sv | 30 +++
 rtl/mc_decode.sv | 23 ++
 rtl/mc_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mc_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_sequencer_pkg.sv
// Shared constants for the multi-cycle sequencer: opcodes, FSM state codes,
// instruction classes and the memory-wait limit used when SEQ_TIMEOUT_EN is defined.
package mc_sequencer_pkg;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;

   typedef enum logic [1:0] {
      CLS_R    = 2'd0,
      CLS_ADDI = 2'd1,
      CLS_SW   = 2'd2,
      CLS_LW   = 2'd3
   } cls_e;

   // Last wait count before a stalled FETCH/MEM is abandoned.
   localparam logic [3:0] WAIT_MAX = 4'd15;

   function automatic logic is_mem_cls(input cls_e c);
      return (c == CLS_SW) || (c == CLS_LW);
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode-to-class decode for mc_sequencer; unknown opcodes
// raise o_illegal and report class R.
module mc_decode
   import mc_sequencer_pkg::*;
(
   input  logic [4:0] i_opcode,
   output logic [1:0] o_cls,
   output logic       o_illegal
);

   always_comb begin
      o_cls     = CLS_R;
      o_illegal = 1'b0;
      case (i_opcode)
         OP_RTYPE: o_cls = CLS_R;
         OP_ADDI:  o_cls = CLS_ADDI;
         OP_SW:    o_cls = CLS_SW;
         OP_LW:    o_cls = CLS_LW;
         default:  o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer FSM (FETCH/DECODE/EXEC/MEM/WB).
// Define SEQ_TIMEOUT_EN to abort FETCH/MEM waits after 16 stalled cycles.
module mc_sequencer
   import mc_sequencer_pkg::*;
(
   input  logic       clock,
   input  logic       resetn,
   input  logic [4:0] opcode,
   input  logic [4:0] func,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_req,
   output logic       ir_we,
   output logic       pc_we,
   output logic       Rwe,
   output logic       Rdst,
   output logic       ALUinB,
   output logic [4:0] ALUop,
   output logic       dmem_req,
   output logic       DMwe,
   output logic       Rwd,
   output logic [2:0] state,
   output logic       illegal,
   output logic       timeout
);

   logic [2:0] r_state;
   cls_e       r_cls;
   logic [4:0] r_func;

   logic [1:0] w_dec_cls;
   logic       w_dec_illegal;
   logic [2:0] w_next_state;
   logic       w_wait_expired;
   logic       w_timeout;
   logic       w_sel_active;

   logic       w_imem_req, w_ir_we, w_pc_we, w_rwe;
   logic       w_rdst, w_aluinb, w_dmem_req, w_dmwe, w_rwd, w_illegal;
   logic [4:0] w_aluop;

   mc_decode u_decode (
      .i_opcode  (opcode),
      .o_cls     (w_dec_cls),
      .o_illegal (w_dec_illegal)
   );

   always_comb begin
      w_next_state = ST_FETCH;
      w_imem_req   = 1'b0;
      w_ir_we      = 1'b0;
      w_pc_we      = 1'b0;
      w_rwe        = 1'b0;
      w_dmem_req   = 1'b0;
      w_dmwe       = 1'b0;
      w_illegal    = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_imem_req = 1'b1;
            if (imem_ready) begin
               w_ir_we      = 1'b1;
               w_next_state = ST_DECODE;
            end else if (w_wait_expired) begin
               w_timeout    = 1'b1;
               w_next_state = ST_FETCH;
            end else begin
               w_next_state = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (w_dec_illegal) begin
               w_illegal    = 1'b1;
               w_pc_we      = 1'b1;
               w_next_state = ST_FETCH;
            end else begin
               w_next_state = ST_EXEC;
            end
         end
         ST_EXEC: begin
            w_next_state = is_mem_cls(r_cls) ? ST_MEM : ST_WB;
         end
         ST_MEM: begin
            w_dmem_req = 1'b1;
            w_dmwe     = (r_cls == CLS_SW);
            if (dmem_ready) begin
               // A store retires here; a load still has to write back.
               w_pc_we      = (r_cls == CLS_SW);
               w_next_state = (r_cls == CLS_SW) ? ST_FETCH : ST_WB;
            end else if (w_wait_expired) begin
               w_timeout    = 1'b1;
               w_next_state = ST_FETCH;
            end else begin
               w_next_state = ST_MEM;
            end
         end
         ST_WB: begin
            w_rwe        = 1'b1;
            w_pc_we      = 1'b1;
            w_next_state = ST_FETCH;
         end
         default: w_next_state = ST_FETCH;
      endcase
   end

   // Datapath selects follow the latched class only while it is meaningful.
   always_comb begin
      w_sel_active = (r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB);
      w_rdst       = 1'b0;
      w_aluinb     = 1'b0;
      w_rwd        = 1'b0;
      w_aluop      = 5'b00000;
      if (w_sel_active) begin
         w_rdst   = (r_cls == CLS_ADDI) || (r_cls == CLS_LW);
         w_aluinb = (r_cls == CLS_ADDI) || (r_cls == CLS_SW) || (r_cls == CLS_LW);
         w_rwd    = (r_cls == CLS_LW);
         w_aluop  = (r_cls == CLS_R) ? r_func : 5'b00000;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_FETCH;
         r_cls   <= CLS_R;
         r_func  <= 5'b00000;
      end else begin
         r_state <= w_next_state;
         if (r_state == ST_DECODE) begin
            r_cls  <= cls_e'(w_dec_cls);
            r_func <= func;
         end
      end
   end

`ifdef SEQ_TIMEOUT_EN
   logic [3:0] r_wait_cnt;
   logic       w_waiting;

   assign w_waiting = ((r_state == ST_FETCH) && !imem_ready) ||
                      ((r_state == ST_MEM)   && !dmem_ready);

   // Any state change (including the timeout retry of FETCH) restarts the count.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_wait_cnt <= 4'd0;
      end else if ((w_next_state != r_state) || w_timeout) begin
         r_wait_cnt <= 4'd0;
      end else if (w_waiting) begin
         r_wait_cnt <= r_wait_cnt + 4'd1;
      end
   end

   assign w_wait_expired = (r_wait_cnt == WAIT_MAX);
`else
   assign w_wait_expired = 1'b0;
`endif

   // Outputs are forced low for as long as reset is held, independent of the clock.
   assign imem_req = w_imem_req & resetn;
   assign ir_we    = w_ir_we    & resetn;
   assign pc_we    = w_pc_we    & resetn;
   assign Rwe      = w_rwe      & resetn;
   assign Rdst     = w_rdst     & resetn;
   assign ALUinB   = w_aluinb   & resetn;
   assign ALUop    = w_aluop    & {5{resetn}};
   assign dmem_req = w_dmem_req & resetn;
   assign DMwe     = w_dmwe     & resetn;
   assign Rwd      = w_rwd      & resetn;
   assign illegal  = w_illegal  & resetn;
   assign timeout  = w_timeout  & resetn;
   assign state    = r_state;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: a directed vector table, random
// instruction streams checked against a per-instruction trace model, and reset/timeout corners.
module tb_mc_sequencer;

`ifdef SEQ_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   typedef struct packed {
      logic [2:0] st;
      logic       imem_req;
      logic       ir_we;
      logic       pc_we;
      logic       rwe;
      logic       rdst;
      logic       aluinb;
      logic [4:0] aluop;
      logic       dmem_req;
      logic       dmwe;
      logic       rwd;
      logic       illegal;
      logic       timeout;
   } obs_t;

   typedef struct packed {
      logic       ir;
      logic       dr;
      logic [4:0] op;
      logic [4:0] fn;
   } drv_t;

   typedef struct {
      logic [4:0] op;
      logic [4:0] fn;
      int         fd;
      int         md;
      int         exp_lat;
      int         exp_rwe;
      string      name;
   } vec_t;

   localparam int OBS_W = $bits(obs_t);

   logic       clock = 1'b0;
   logic       resetn;
   logic [4:0] opcode, func;
   logic       imem_ready, dmem_ready;
   logic       imem_req, ir_we, pc_we, Rwe, Rdst, ALUinB, dmem_req, DMwe, Rwd, illegal, timeout;
   logic [4:0] ALUop;
   logic [2:0] state;

   logic [OBS_W-1:0] exp_q[$];
   drv_t             drv_q[$];
   int               n_checks = 0;
   int               n_fail   = 0;

   mc_sequencer dut (
      .clock      (clock),
      .resetn     (resetn),
      .opcode     (opcode),
      .func       (func),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .imem_req   (imem_req),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .Rwe        (Rwe),
      .Rdst       (Rdst),
      .ALUinB     (ALUinB),
      .ALUop      (ALUop),
      .dmem_req   (dmem_req),
      .DMwe       (DMwe),
      .Rwd        (Rwd),
      .state      (state),
      .illegal    (illegal),
      .timeout    (timeout)
   );

   always #5 clock = ~clock;

   function automatic obs_t sample();
      obs_t o;
      o.st = state; o.imem_req = imem_req; o.ir_we = ir_we; o.pc_we = pc_we;
      o.rwe = Rwe; o.rdst = Rdst; o.aluinb = ALUinB; o.aluop = ALUop;
      o.dmem_req = dmem_req; o.dmwe = DMwe; o.rwd = Rwd;
      o.illegal = illegal; o.timeout = timeout;
      return o;
   endfunction

   function automatic drv_t rand_drv();
      drv_t d;
      d.ir = 1'($urandom); d.dr = 1'($urandom);
      d.op = 5'($urandom); d.fn = 5'($urandom);
      return d;
   endfunction

   // Instruction class straight from the opcode table: 0=R 1=ADDI 2=SW 3=LW, -1 unsupported.
   function automatic int class_of(input logic [4:0] op);
      case (op)
         5'b00000: return 0;
         5'b00101: return 1;
         5'b00111: return 2;
         5'b01000: return 3;
         default:  return -1;
      endcase
   endfunction

   function automatic obs_t sel_obs(input int cls, input logic [4:0] fn, input logic [2:0] st);
      obs_t o;
      o        = '0;
      o.st     = st;
      o.rdst   = (cls == 1) || (cls == 3);
      o.aluinb = (cls != 0);
      o.rwd    = (cls == 3);
      o.aluop  = (cls == 0) ? fn : 5'b00000;
      return o;
   endfunction

   function automatic void push(input obs_t o, input drv_t d);
      exp_q.push_back(o);
      drv_q.push_back(d);
   endfunction

   // Expected per-cycle trace of one instruction: fd stalled fetch cycles, md stalled memory cycles.
   task automatic build(input logic [4:0] op, input logic [4:0] fn, input int fd, input int md,
                        output int exp_pc, output int exp_rwe, output int exp_tmo);
      obs_t o;
      drv_t d;
      int   cls, cnt;
      cls = class_of(op);
      exp_pc = 0; exp_rwe = 0; exp_tmo = 0;
      cnt = 0;
      for (int k = 0; k <= fd; k++) begin
         o = '0; o.st = 3'd0; o.imem_req = 1'b1;
         d = rand_drv(); d.ir = (k == fd);
         if (k == fd) o.ir_we = 1'b1;
         else if (TMO && cnt == 15) begin o.timeout = 1'b1; cnt = 0; exp_tmo++; end
         else cnt++;
         push(o, d);
      end
      o = '0; o.st = 3'd1;
      d = rand_drv(); d.op = op; d.fn = fn;
      if (cls < 0) begin
         o.illegal = 1'b1; o.pc_we = 1'b1; exp_pc = 1;
         push(o, d);
         return;
      end
      push(o, d);
      push(sel_obs(cls, fn, 3'd2), rand_drv());
      if (cls >= 2) begin
         for (int k = 0; k <= md; k++) begin
            o = sel_obs(cls, fn, 3'd3); o.dmem_req = 1'b1; o.dmwe = (cls == 2);
            d = rand_drv(); d.dr = (k == md);
            if (k == md) begin
               if (cls == 2) begin o.pc_we = 1'b1; exp_pc = 1; end
               push(o, d);
               if (cls == 2) return;
               break;
            end else if (TMO && k == 15) begin
               o.timeout = 1'b1; exp_tmo = exp_tmo + 1;
               push(o, d);
               return;
            end
            push(o, d);
         end
      end
      o = sel_obs(cls, fn, 3'd4); o.rwe = 1'b1; o.pc_we = 1'b1;
      exp_pc = 1; exp_rwe = 1;
      push(o, rand_drv());
   endtask

   task automatic check(input string nm, input logic [OBS_W-1:0] got, input logic [OBS_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   task automatic check_int(input string nm, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   // Plays up to max_cyc cycles of the queued trace, comparing every cycle.
   task automatic run_queue(input string nm, input int max_cyc,
                            output int lat, output int npc, output int nrwe, output int ntmo);
      int   n;
      drv_t d;
      obs_t o;
      n = exp_q.size();
      if (max_cyc < n) n = max_cyc;
      lat = 0; npc = 0; nrwe = 0; ntmo = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         d = drv_q.pop_front();
         imem_ready = d.ir; dmem_ready = d.dr; opcode = d.op; func = d.fn;
         #1;
         o = sample();
         check($sformatf("%s cyc%0d", nm, i), o, exp_q.pop_front());
         if (o.pc_we) begin npc++; if (lat == 0) lat = i + 1; end
         if (o.rwe) nrwe++;
         if (o.timeout) ntmo++;
      end
      exp_q.delete();
      drv_q.delete();
   endtask

   initial begin
      vec_t vecs[11];
      obs_t e;
      drv_t d;
      int   lat, npc, nrwe, ntmo, epc, erwe, etmo;
      logic [4:0] op;

      vecs[0]  = '{5'b00000, 5'b00000, 0, 0, 4, 1, "r_add"};
      vecs[1]  = '{5'b00000, 5'b00001, 0, 0, 4, 1, "r_sub"};
      vecs[2]  = '{5'b00000, 5'b10101, 0, 0, 4, 1, "r_func15"};
      vecs[3]  = '{5'b00101, 5'b11010, 0, 0, 4, 1, "addi"};
      vecs[4]  = '{5'b00111, 5'b00000, 0, 0, 4, 0, "sw"};
      vecs[5]  = '{5'b01000, 5'b00000, 0, 3, 8, 1, "lw_wait3"};
      vecs[6]  = '{5'b01000, 5'b00011, 0, 0, 5, 1, "lw"};
      vecs[7]  = '{5'b11111, 5'b00000, 0, 0, 2, 0, "illegal_1f"};
      vecs[8]  = '{5'b00001, 5'b00000, 0, 0, 2, 0, "illegal_01"};
      vecs[9]  = '{5'b00000, 5'b00100, 2, 0, 6, 1, "r_fetch_wait2"};
      vecs[10] = '{5'b00111, 5'b00000, 1, 2, 7, 0, "sw_waits"};

      // Outputs must stay low while reset is held, whatever the inputs do.
      resetn = 1'b0;
      imem_ready = 1'b1; dmem_ready = 1'b1; opcode = '0; func = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         d = rand_drv();
         imem_ready = d.ir; dmem_ready = d.dr; opcode = d.op; func = d.fn;
         #1;
         check($sformatf("reset_hold%0d", i), sample(), '0);
      end
      @(negedge clock);
      resetn = 1'b1; imem_ready = 1'b0;
      #1;
      e = '0; e.st = 3'd0; e.imem_req = 1'b1;
      check("first_fetch", sample(), e);

      foreach (vecs[v]) begin
         build(vecs[v].op, vecs[v].fn, vecs[v].fd, vecs[v].md, epc, erwe, etmo);
         run_queue(vecs[v].name, 1000, lat, npc, nrwe, ntmo);
         check_int({vecs[v].name, " latency"}, lat, vecs[v].exp_lat);
         check_int({vecs[v].name, " pc_we count"}, npc, 1);
         check_int({vecs[v].name, " Rwe count"}, nrwe, vecs[v].exp_rwe);
      end

      // Random instruction stream with random stalls and junk on idle inputs.
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 4))
            0: op = 5'b00000;
            1: op = 5'b00101;
            2: op = 5'b00111;
            3: op = 5'b01000;
            default: op = 5'($urandom);
         endcase
         build(op, 5'($urandom), $urandom_range(0, 6), $urandom_range(0, 6), epc, erwe, etmo);
         run_queue($sformatf("rand%0d_op%02h", n, op), 1000, lat, npc, nrwe, ntmo);
         check_int($sformatf("rand%0d pc_we count", n), npc, epc);
         check_int($sformatf("rand%0d Rwe count", n), nrwe, erwe);
      end

      // Reset dropped mid-cycle while a load waits in MEM.
      build(5'b01000, 5'b00000, 0, 20, epc, erwe, etmo);
      run_queue("lw_abort", 5, lat, npc, nrwe, ntmo);
      #2;
      resetn = 1'b0;
      #1;
      check("abort_async", sample(), '0);
      @(negedge clock);
      dmem_ready = 1'b1; imem_ready = 1'b1;
      #1;
      check("abort_held", sample(), '0);
      @(negedge clock);
      resetn = 1'b1; imem_ready = 1'b0;
      #1;
      check("abort_release_fetch", sample(), e);
      build(5'b00000, 5'b00010, 0, 0, epc, erwe, etmo);
      run_queue("after_abort", 1000, lat, npc, nrwe, ntmo);
      check_int("after_abort latency", lat, 4);

      // Load whose data memory never answers for 20 cycles.
      build(5'b01000, 5'b00000, 0, 20, epc, erwe, etmo);
      run_queue("lw_long_wait", 1000, lat, npc, nrwe, ntmo);
      check_int("long_wait timeout count", ntmo, TMO ? 1 : 0);
      check_int("long_wait pc_we count", npc, TMO ? 0 : 1);
      check_int("long_wait Rwe count", nrwe, TMO ? 0 : 1);
      build(5'b00101, 5'b00000, 0, 0, epc, erwe, etmo);
      run_queue("after_long_wait", 1000, lat, npc, nrwe, ntmo);
      check_int("after_long_wait latency", lat, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
